uart_rx_ctrl: RTL and testbench

- Frame sequencer for the UART receiver.
- Detects the start edge on the serial line and runs the per-bit edge/bit counters.
- Enables the mid-bit sampler and drives its `edge_count`.
- Strobes the deserializer and parity checker at bit end.
- Checks start glitch and stop bit itself, and issues a one-cycle `data_valid` per good frame.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_ctrl_if.sv | 31 +++
 rtl/edge_bit_counter.sv | 41 ++++
 rtl/uart_rx_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared widths and frame-sequencer state encoding for the UART receiver
// Contents: PRESCALE_W (oversample counter width), BIT_CNT_W (bit-in-frame counter width),
//           rx_state_t (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;
    localparam int BIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - signal bundle between the frame sequencer and its environment
// master: drives RX_IN, PAR_EN, Prescale, sampled_bit, par_err_in; observes the sequencer outputs.
// slave : the sequencer; drives dat_samp_en, edge_count, deser_en, par_chk_en,
//         data_valid, par_error, stp_error.
interface uart_rx_ctrl_if;
    import uart_rx_pkg::*;

    logic                  RX_IN;
    logic                  PAR_EN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  sampled_bit;
    logic                  par_err_in;
    logic                  dat_samp_en;
    logic [PRESCALE_W-1:0] edge_count;
    logic                  deser_en;
    logic                  par_chk_en;
    logic                  data_valid;
    logic                  par_error;
    logic                  stp_error;

    modport master (
        output RX_IN, PAR_EN, Prescale, sampled_bit, par_err_in,
        input  dat_samp_en, edge_count, deser_en, par_chk_en, data_valid, par_error, stp_error
    );

    modport slave (
        input  RX_IN, PAR_EN, Prescale, sampled_bit, par_err_in,
        output dat_samp_en, edge_count, deser_en, par_chk_en, data_valid, par_error, stp_error
    );

endinterface

// File: rtl/edge_bit_counter.sv
// rtl/edge_bit_counter.sv - oversample edge counter and bit-in-frame counter
// Ports: CLK, RST (async, active-high); enable (count when 1, clear when 0);
//        prescale (latched oversampling ratio); edge_count (0..prescale-1);
//        bit_count (bits completed in this frame); last (edge_count == prescale-1).
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  last
);

    logic [PRESCALE_W-1:0] r_edge_count;
    logic [BIT_CNT_W-1:0]  r_bit_count;
    logic [PRESCALE_W-1:0] w_prescale_m1;

    assign w_prescale_m1 = prescale - PRESCALE_W'(1);
    assign last          = (r_edge_count == w_prescale_m1);
    assign edge_count    = r_edge_count;
    assign bit_count     = r_bit_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_count <= '0;
            r_bit_count  <= '0;
        end else if (!enable) begin
            r_edge_count <= '0;
            r_bit_count  <= '0;
        end else if (last) begin
            r_edge_count <= '0;
            r_bit_count  <= r_bit_count + BIT_CNT_W'(1);
        end else begin
            r_edge_count <= r_edge_count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer: start detect, bit timing, strobes, error/valid flags
// Ports: CLK, RST (async, active-high); bus (uart_rx_ctrl_if.slave) carrying the serial line,
//        frame configuration, sampler/parity inputs and all sequencer outputs.
// Parameter: DATA_WIDTH, data bits per frame (5..8).
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.slave  bus
);

    rx_state_t             r_state;
    rx_state_t             w_next;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en;
    logic                  r_par_error;
    logic                  r_stp_error;
    logic                  r_data_valid;

    logic                  w_cnt_en;
    logic                  w_last;
    logic [PRESCALE_W-1:0] w_edge_count;
    logic [BIT_CNT_W-1:0]  w_bit_count;
    logic                  w_deser_en;
    logic                  w_par_chk_en;
    logic                  w_start_edge;

    assign w_start_edge = (r_state == IDLE) && !bus.RX_IN;

    // Counting stops on the cycle the frame ends as well as in IDLE, so the
    // counters already read 0 in the first IDLE cycle and the first START cycle.
    assign w_cnt_en = (r_state != IDLE) && (w_next != IDLE);

    edge_bit_counter u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (w_cnt_en),
        .prescale   (r_prescale),
        .edge_count (w_edge_count),
        .bit_count  (w_bit_count),
        .last       (w_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // bit_count is 0 during START, so data bit k (0-based) ends with bit_count == k+1.
    always_comb begin
        w_next       = r_state;
        w_deser_en   = 1'b0;
        w_par_chk_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.RX_IN) w_next = START;
            end
            START: begin
                if (w_last) w_next = bus.sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_last) begin
                    w_deser_en = 1'b1;
                    if (w_bit_count == BIT_CNT_W'(DATA_WIDTH)) begin
                        w_next = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_last) begin
                    w_par_chk_en = 1'b1;
                    w_next       = STOP;
                end
            end
            STOP: begin
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prescale   <= '0;
            r_par_en     <= 1'b0;
            r_par_error  <= 1'b0;
            r_stp_error  <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= (r_state == STOP) && w_last && bus.sampled_bit && !r_par_error;
            if (w_start_edge) begin
                r_prescale  <= bus.Prescale;
                r_par_en    <= bus.PAR_EN;
                r_par_error <= 1'b0;
                r_stp_error <= 1'b0;
            end
            if (w_par_chk_en) begin
                r_par_error <= bus.par_err_in;
            end
            if ((r_state == STOP) && w_last) begin
                r_stp_error <= ~bus.sampled_bit;
            end
        end
    end

    assign bus.dat_samp_en = (r_state != IDLE);
    assign bus.edge_count  = w_edge_count;
    assign bus.deser_en    = w_deser_en;
    assign bus.par_chk_en  = w_par_chk_en;
    assign bus.data_valid  = r_data_valid;
    assign bus.par_error   = r_par_error;
    assign bus.stp_error   = r_stp_error;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a sampler model and frame-slot reference
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_ctrl_if u_if();

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (u_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int cur_p = 8;
    int votes = 0;
    logic prev_samp = 1'b0;

    int obs_deser[$], obs_bits[$], obs_par[$], obs_dv[$], obs_fall[$];
    int exp_deser[$], exp_bits[$], exp_par[$], exp_dv[$], exp_fall[$];
    int exp_perr = 0;
    int exp_serr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-bit majority sampler: three votes at edges p/2-2..p/2 of every bit.
    always @(posedge clk) begin
        if (rst || !u_if.dat_samp_en) begin
            votes <= 0;
            u_if.sampled_bit <= 1'b1;
        end else if (int'(u_if.edge_count) == cur_p/2 - 2) begin
            votes <= int'(u_if.RX_IN);
        end else if (int'(u_if.edge_count) > cur_p/2 - 2 && int'(u_if.edge_count) <= cur_p/2) begin
            votes <= votes + int'(u_if.RX_IN);
            if (int'(u_if.edge_count) == cur_p/2)
                u_if.sampled_bit <= ((votes + int'(u_if.RX_IN)) >= 2);
        end
    end

    // Event log, sampled on the falling edge; the cycle stamp is the count of rising edges so far.
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.deser_en) begin
                obs_deser.push_back(cyc);
                obs_bits.push_back(int'(u_if.sampled_bit));
            end
            if (u_if.par_chk_en) obs_par.push_back(cyc);
            if (u_if.data_valid) obs_dv.push_back(cyc);
            if (prev_samp && !u_if.dat_samp_en) obs_fall.push_back(cyc);
        end
        prev_samp <= u_if.dat_samp_en;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input int o[$], input int e[$]);
        chk({tag, "_count"}, o.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk(tag, (i < o.size()) ? o[i] : -1, e[i]);
    endtask

    task automatic clear_q();
        obs_deser.delete(); obs_bits.delete(); obs_par.delete(); obs_dv.delete(); obs_fall.delete();
        exp_deser.delete(); exp_bits.delete(); exp_par.delete(); exp_dv.delete(); exp_fall.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_samp_en"}, int'(u_if.dat_samp_en), 0);
        chk({tag, "_edge"},    int'(u_if.edge_count), 0);
        chk({tag, "_deser"},   int'(u_if.deser_en), 0);
        chk({tag, "_parchk"},  int'(u_if.par_chk_en), 0);
        chk({tag, "_dv"},      int'(u_if.data_valid), 0);
        chk({tag, "_perr"},    int'(u_if.par_error), 0);
        chk({tag, "_serr"},    int'(u_if.stp_error), 0);
    endtask

    // Reference: a frame is a run of p-cycle slots starting at rising edge s
    // (start, data LSB first, optional parity, stop); slot j ends in cycle s+(j+1)*p-1.
    task automatic add_expect(input int s, input int p, input bit pe, input logic [7:0] d,
                              input bit stop, input bit perr, input bit glitch);
        int nb;
        logic [7:0] dd;
        dd = d;
        if (glitch) begin
            exp_fall.push_back(s + p);
            exp_perr = 0;
            exp_serr = 0;
            return;
        end
        for (int k = 0; k < DW; k++) begin
            exp_deser.push_back(s + (k + 2) * p - 1);
            exp_bits.push_back(int'(dd[k]));
        end
        nb = DW + 2 + (pe ? 1 : 0);
        if (pe) exp_par.push_back(s + (DW + 2) * p - 1);
        if (stop && !(pe && perr)) exp_dv.push_back(s + nb * p);
        exp_fall.push_back(s + nb * p);
        exp_perr = (pe && perr) ? 1 : 0;
        exp_serr = stop ? 0 : 1;
    endtask

    task automatic send_frame(input int p, input bit pe, input logic [7:0] d, input bit stop,
                              input bit perr, input int glitch_len, input int abort_at,
                              input int chg_p, output int s);
        bit line[$];
        logic [7:0] dd;
        dd = d;
        u_if.Prescale   = 6'(p);
        u_if.PAR_EN     = pe;
        u_if.par_err_in = perr;
        cur_p = p;
        s = -1;
        if (glitch_len > 0) begin
            for (int i = 0; i < glitch_len; i++) line.push_back(1'b0);
            for (int i = 0; i < p + 4; i++) line.push_back(1'b1);
        end else begin
            for (int i = 0; i < p; i++) line.push_back(1'b0);
            for (int k = 0; k < DW; k++)
                for (int i = 0; i < p; i++) line.push_back(dd[k]);
            if (pe)
                for (int i = 0; i < p; i++) line.push_back(^dd);
            for (int i = 0; i < p; i++) line.push_back(stop);
            line.push_back(1'b1);
        end
        for (int n = 0; n < line.size(); n++) begin
            @(negedge clk);
            if (n == 0) s = cyc + 1;
            if (abort_at > 0 && n == abort_at) begin
                rst = 1'b1;
                #1;
                chk_zero("abort");
                u_if.RX_IN = 1'b1;
                return;
            end
            if (n == 1) begin
                chk("start_samp_en", int'(u_if.dat_samp_en), 1);
                chk("start_edge0",   int'(u_if.edge_count), 0);
                chk("start_perr_clr", int'(u_if.par_error), 0);
                chk("start_serr_clr", int'(u_if.stp_error), 0);
            end
            if (chg_p > 0 && n == 3 * p) u_if.Prescale = 6'(chg_p);
            u_if.RX_IN = line[n];
        end
    endtask

    task automatic settle_and_check(input string tag);
        repeat (6) @(negedge clk);
        cmp_q({tag, "_deser_at"}, obs_deser, exp_deser);
        cmp_q({tag, "_bits"},     obs_bits,  exp_bits);
        cmp_q({tag, "_parchk_at"}, obs_par,  exp_par);
        cmp_q({tag, "_dv_at"},    obs_dv,    exp_dv);
        cmp_q({tag, "_idle_at"},  obs_fall,  exp_fall);
        chk({tag, "_par_error"}, int'(u_if.par_error), exp_perr);
        chk({tag, "_stp_error"}, int'(u_if.stp_error), exp_serr);
    endtask

    initial begin
        int s, s1, s2, p;
        bit pe, stop, perr;
        logic [7:0] d;
        int plist[3];
        plist[0] = 8; plist[1] = 16; plist[2] = 32;

        rst = 1'b1;
        u_if.RX_IN = 1'b1;
        u_if.PAR_EN = 1'b0;
        u_if.Prescale = 6'd8;
        u_if.par_err_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0x55 at prescale 8, no parity
        clear_q();
        send_frame(8, 1'b0, 8'h55, 1'b1, 1'b0, 0, 0, 0, s);
        add_expect(s, 8, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
        settle_and_check("p8_55");

        // 0xA3 at prescale 16 with parity, parity checker reports an error
        clear_q();
        send_frame(16, 1'b1, 8'hA3, 1'b1, 1'b1, 0, 0, 0, s);
        add_expect(s, 16, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0);
        settle_and_check("p16_parerr");

        // prescale 32, stop bit low
        clear_q();
        d = 8'($urandom);
        send_frame(32, 1'b0, d, 1'b0, 1'b0, 0, 0, 0, s);
        add_expect(s, 32, 1'b0, d, 1'b0, 1'b0, 1'b0);
        settle_and_check("p32_stperr");

        // 3-cycle low glitch at prescale 16; flags from the previous frame clear on entry
        clear_q();
        send_frame(16, 1'b0, 8'h00, 1'b1, 1'b0, 3, 0, 0, s);
        add_expect(s, 16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        settle_and_check("glitch");

        // back-to-back frames at prescale 8, Prescale input moved to 16 inside the second
        clear_q();
        d = 8'($urandom);
        send_frame(8, 1'b0, d, 1'b1, 1'b0, 0, 0, 0, s1);
        add_expect(s1, 8, 1'b0, d, 1'b1, 1'b0, 1'b0);
        d = 8'($urandom);
        send_frame(8, 1'b0, d, 1'b1, 1'b0, 0, 0, 16, s2);
        add_expect(s2, 8, 1'b0, d, 1'b1, 1'b0, 1'b0);
        settle_and_check("b2b");

        // reset in the middle of data bit 4, then a clean frame
        clear_q();
        send_frame(16, 1'b0, 8'($urandom), 1'b1, 1'b0, 0, 16 * 5 + 8, 0, s);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_q();
        d = 8'($urandom);
        send_frame(16, 1'b0, d, 1'b1, 1'b0, 0, 0, 0, s);
        add_expect(s, 16, 1'b0, d, 1'b1, 1'b0, 1'b0);
        settle_and_check("post_reset");

        // randomized frames
        for (int t = 0; t < 8; t++) begin
            clear_q();
            p    = plist[$urandom_range(0, 2)];
            pe   = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            perr = ($urandom_range(0, 2) == 0);
            d    = 8'($urandom);
            send_frame(p, pe, d, stop, perr, 0, 0, 0, s);
            add_expect(s, p, pe, d, stop, perr, 1'b0);
            settle_and_check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
